// File: rtl/ram_wait_responder.sv
// Memory-side RAM endpoint: a word store with byte-enable writes that answers each
// request after a run-time-programmable number of wait states, signalled on delay.
module ram_wait_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   data_w,
  output logic [DATA_WIDTH-1:0]   data_r,
  output logic                    delay,
  input  logic [WAIT_WIDTH-1:0]   wait_states,
  output logic                    err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [WAIT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    delay_q;
  logic [DATA_WIDTH-1:0]   data_r_q, data_r_d;
  logic                    err_q, err_d;

  // Request captured at acceptance; only this copy is used while waiting.
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [BYTES-1:0]        be_q;
  logic [DATA_WIDTH-1:0]   data_w_q;

  logic                    latch_en;
  logic                    exec_en;
  logic [ADDR_WIDTH-1:0]   exec_addr;
  logic                    exec_we;
  logic [BYTES-1:0]        exec_be;
  logic [DATA_WIDTH-1:0]   exec_data;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   mem_index;
  logic                    mem_wr;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    exec_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          latch_en = 1'b1;
          if (wait_states == '0) begin
            exec_en = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_states - WAIT_WIDTH'(1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end else begin
          exec_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A zero-wait access executes straight from the ports; a delayed one from the latched copy.
  always_comb begin
    exec_addr = (state_q == S_WAIT) ? addr_q   : addr;
    exec_we   = (state_q == S_WAIT) ? we_q     : we;
    exec_be   = (state_q == S_WAIT) ? be_q     : be;
    exec_data = (state_q == S_WAIT) ? data_w_q : data_w;
    in_range  = (exec_addr[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
    mem_index = exec_addr[DEPTH_LOG2-1:0];
    mem_wr    = exec_en && exec_we && in_range && !reset;

    data_r_d = data_r_q;
    err_d    = err_q;
    if (exec_en) begin
      if (!in_range) begin
        err_d = 1'b1;
      end
      if (!exec_we) begin
        data_r_d = in_range ? mem[mem_index] : '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      delay_q  <= 1'b0;
      data_r_q <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      data_w_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= (state_d == S_WAIT);
      data_r_q <= data_r_d;
      err_q    <= err_d;
      if (latch_en) begin
        addr_q   <= addr;
        we_q     <= we;
        be_q     <= be;
        data_w_q <= data_w;
      end
    end
  end

  // NOTE: the store has no reset; clearing a RAM array would defeat RAM
  // inference and its contents are undefined until written anyway.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < BYTES; i++) begin
        if (exec_be[i]) begin
          mem[mem_index][8*i +: 8] <= exec_data[8*i +: 8];
        end
      end
    end
  end

  assign data_r = data_r_q;
  assign delay  = delay_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ram_wait_responder.sv
// Self-checking bench for ram_wait_responder: directed scenarios plus randomized
// accesses compared against an array-based reference of the store and its timing.
module tb_ram_wait_responder;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DL    = 10;
  localparam int WW    = 4;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [AW-1:0] addr;
  logic          we;
  logic [3:0]    be;
  logic [DW-1:0] data_w;
  logic [DW-1:0] data_r;
  logic          delay;
  logic [WW-1:0] wait_states;
  logic          err;

  ram_wait_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .WAIT_WIDTH(WW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .addr(addr), .we(we), .be(be),
    .data_w(data_w), .data_r(data_r), .delay(delay),
    .wait_states(wait_states), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference: plain array of words, last read value and sticky error.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_data_r;
  logic          ref_err;
  int            last_accept;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the access to the reference, following the memory rules directly.
  task automatic ref_apply(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                           input logic [DW-1:0] d);
    if (a < DEPTH) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      end else begin
        ref_data_r = ref_mem[a];
      end
    end else begin
      ref_err = 1'b1;
      if (!w) ref_data_r = '0;
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the first cycle after the access.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                        input logic [DW-1:0] d, input int n, input bit scramble,
                        input string tag);
    logic [WW-1:0] n_w;
    n_w         = WW'(n);
    en          = 1'b1;
    we          = w;
    addr        = a;
    be          = b;
    data_w      = d;
    wait_states = n_w;
    @(posedge clk);
    last_accept = cyc;
    ref_apply(w, a, b, d);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      check({tag, " delay_wait"}, {31'b0, delay}, 32'd1);
      if (scramble) begin
        en          = 1'($urandom);
        we          = 1'($urandom);
        addr        = $urandom;
        be          = 4'($urandom);
        data_w      = $urandom;
        wait_states = WW'($urandom);
      end
    end
    @(negedge clk);
    check({tag, " delay_done"}, {31'b0, delay}, 32'd0);
    check({tag, " data_r"}, data_r, ref_data_r);
    check({tag, " err"}, {31'b0, err}, {31'b0, ref_err});
    en = 1'b0;
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] pre9;
    int            prev_accept;
    logic [AW-1:0] ra;

    reset = 1'b1; en = 1'b0; we = 1'b0; addr = '0; be = '0; data_w = '0; wait_states = '0;
    ref_data_r = '0; ref_err = 1'b0;
    repeat (2) @(negedge clk);
    check("reset delay", {31'b0, delay}, 32'd0);
    check("reset data_r", data_r, 32'd0);
    check("reset err", {31'b0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++)
      access(1'b1, AW'(i), 4'hF, $urandom, 0, 1'b0, "prefill");

    // Zero-wait write then read.
    access(1'b1, 32'd5, 4'hF, 32'hDEADBEEF, 0, 1'b0, "zw_write");
    access(1'b0, 32'd5, 4'h0, 32'h0, 0, 1'b0, "zw_read");
    check("zw_read const", data_r, 32'hDEADBEEF);

    // Byte enables.
    access(1'b1, 32'd7, 4'hF, 32'h11223344, 0, 1'b0, "be_init");
    access(1'b1, 32'd7, 4'b0101, 32'hAABBCCDD, 0, 1'b0, "be_write");
    access(1'b0, 32'd7, 4'hF, 32'h0, 0, 1'b0, "be_read");
    check("be_read const", data_r, 32'h11BB33DD);

    // Three wait states with inputs disturbed while waiting.
    access(1'b0, 32'd5, 4'h0, 32'h0, 3, 1'b1, "ws3_read");
    check("ws3_read const", data_r, 32'hDEADBEEF);

    // Back-to-back reads with two wait states.
    prev_accept = -1;
    for (int k = 0; k < 4; k++) begin
      access(1'b0, (k % 2 == 0) ? 32'd5 : 32'd7, 4'h0, 32'h0, 2, 1'b0, "b2b_read");
      if (prev_accept >= 0)
        check("b2b spacing", 32'(last_accept - prev_accept), 32'd3);
      prev_accept = last_accept;
    end

    // Randomized traffic, including some out-of-range and idle gaps.
    for (int k = 0; k < 200; k++) begin
      ra = ($urandom_range(0, 15) == 0) ? (32'h400 + 32'($urandom_range(0, 4095)))
                                        : 32'($urandom_range(0, DEPTH - 1));
      access(1'($urandom), ra, 4'($urandom), $urandom, $urandom_range(0, 15),
             1'($urandom), "rand");
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("idle delay", {31'b0, delay}, 32'd0);
        check("idle data_r", data_r, ref_data_r);
      end
    end

    // Out-of-range accesses alias nothing.
    access(1'b1, 32'h400, 4'hF, 32'hCAFEF00D, 1, 1'b0, "oor_write");
    check("oor_write err", {31'b0, err}, 32'd1);
    access(1'b0, 32'h400, 4'hF, 32'h0, 0, 1'b0, "oor_read");
    check("oor_read const", data_r, 32'd0);
    access(1'b0, 32'h0, 4'hF, 32'h0, 2, 1'b0, "alias_read");

    // Reset in the middle of a delayed write.
    pre9 = ref_mem[9];
    en = 1'b1; we = 1'b1; addr = 32'd9; be = 4'hF; data_w = ~pre9; wait_states = 4'd5;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid delay t+1", {31'b0, delay}, 32'd1);
    @(negedge clk);
    check("rst_mid delay t+2", {31'b0, delay}, 32'd1);
    reset = 1'b1;
    en = 1'b0;
    #1;
    check("rst_mid delay async", {31'b0, delay}, 32'd0);
    check("rst_mid data_r", data_r, 32'd0);
    check("rst_mid err", {31'b0, err}, 32'd0);
    ref_data_r = '0;
    ref_err    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    access(1'b0, 32'd9, 4'h0, 32'h0, 0, 1'b0, "post_rst_read");
    check("post_rst_read const", data_r, pre9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
